charselect_ctrl: RTL and testbench

Game-phase sequencer for the character-select screen. It sequences the title, select, countdown and fight phases, and drives the screen select for the full-screen background ROM mux. It runs one cursor and one lock per player over NUM_CHARS portraits, and feeds cursor index, lock and blink state to the overlay/highlight logic. It issues a one-cycle fight_start pulse to the game core.

---
 rtl/charselect_pkg.sv | 25 ++
 rtl/charselect_ctrl_if.sv | 35 +++
 rtl/charselect_player.sv | 66 ++++++
 rtl/charselect_ctrl.sv | 141 ++++++++++++++
 tb/tb_charselect_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/charselect_pkg.sv
// Shared types for the character-select sequencer: game phases and background screen codes.
// Pure declarations; no latency or flow control involved.
package charselect_pkg;

   typedef enum logic [1:0] {
      PH_TITLE     = 2'd0,
      PH_SELECT    = 2'd1,
      PH_COUNTDOWN = 2'd2,
      PH_FIGHT     = 2'd3
   } phase_e;

   localparam logic [1:0] SCR_TITLE  = 2'd0;
   localparam logic [1:0] SCR_SELECT = 2'd1;
   localparam logic [1:0] SCR_FIGHT  = 2'd2;

   // The countdown runs over the select background, so two phases share one screen.
   function automatic logic [1:0] phase_screen(input phase_e ph);
      case (ph)
         PH_SELECT, PH_COUNTDOWN: phase_screen = SCR_SELECT;
         PH_FIGHT:                phase_screen = SCR_FIGHT;
         default:                 phase_screen = SCR_TITLE;
      endcase
   endfunction

endpackage

// File: rtl/charselect_ctrl_if.sv
// Bundle of frame/key inputs and overlay/screen outputs of the character-select controller.
// master = controller side, slave = video/game side; no handshake, all levels or single-cycle pulses.
interface charselect_ctrl_if #(parameter int NUM_CHARS = 4);
   localparam int CW = $clog2(NUM_CHARS);

   logic          frame_tick;
   logic          start_btn;
   logic          p1_left, p1_right, p1_ok, p1_back;
   logic          p2_left, p2_right, p2_ok, p2_back;
   logic          fight_over;
   logic [1:0]    screen_sel;
   logic [CW-1:0] p1_cursor, p2_cursor;
   logic          p1_locked, p2_locked;
   logic          cursor_blink;
   logic [7:0]    countdown;
   logic          fight_start;

   modport master (
      input  frame_tick, start_btn,
      input  p1_left, p1_right, p1_ok, p1_back,
      input  p2_left, p2_right, p2_ok, p2_back,
      input  fight_over,
      output screen_sel, p1_cursor, p2_cursor, p1_locked, p2_locked,
      output cursor_blink, countdown, fight_start
   );

   modport slave (
      output frame_tick, start_btn,
      output p1_left, p1_right, p1_ok, p1_back,
      output p2_left, p2_right, p2_ok, p2_back,
      output fight_over,
      input  screen_sel, p1_cursor, p2_cursor, p1_locked, p2_locked,
      input  cursor_blink, countdown, fight_start
   );
endinterface

// File: rtl/charselect_player.sv
// One player's key edge detect, wrapping cursor and lock bit; a press in cycle n shows at n+1.
// No backpressure: disabled keys are dropped, but history keeps tracking so held keys never retrigger.
module charselect_player #(
   parameter int NUM_CHARS = 4,
   parameter int INIT      = 0
) (
   input  logic                         vga_clk,
   input  logic                         reset_n,
   input  logic                         key_left,
   input  logic                         key_right,
   input  logic                         key_ok,
   input  logic                         key_back,
   input  logic                         enable_move,
   input  logic                         enable_lock,
   input  logic                         reload,
   input  logic [$clog2(NUM_CHARS)-1:0] reload_value,
   output logic [$clog2(NUM_CHARS)-1:0] cursor,
   output logic                         locked,
   output logic                         back_pressed
);
   localparam int CW = $clog2(NUM_CHARS);
   localparam logic [CW-1:0] LAST = CW'(NUM_CHARS - 1);

   logic [3:0]    hist_q;
   logic          left_p, right_p, ok_p, back_p;
   logic          ok_eff, move_ok;
   logic [CW-1:0] cursor_nxt;

   assign left_p  = key_left  & ~hist_q[3];
   assign right_p = key_right & ~hist_q[2];
   assign ok_p    = key_ok    & ~hist_q[1];
   assign back_p  = key_back  & ~hist_q[0];

   // back beats ok; a simultaneous ok+back also freezes the cursor
   assign back_pressed = back_p & locked & enable_lock;
   assign ok_eff       = ok_p & ~back_p & ~locked & enable_lock;
   assign move_ok      = enable_move & ~locked & ~(ok_p & back_p);

   always_comb begin
      cursor_nxt = cursor;
      if (move_ok && left_p && !right_p)
         cursor_nxt = (cursor == '0) ? LAST : cursor - 1'b1;
      else if (move_ok && right_p && !left_p)
         cursor_nxt = (cursor == LAST) ? '0 : cursor + 1'b1;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_q <= '0;
         cursor <= CW'(INIT);
         locked <= 1'b0;
      end else begin
         hist_q <= {key_left, key_right, key_ok, key_back};
         if (reload) begin
            cursor <= reload_value;
            locked <= 1'b0;
         end else begin
            cursor <= cursor_nxt;
            if (back_pressed)
               locked <= 1'b0;
            else if (ok_eff)
               locked <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/charselect_ctrl.sv
// Title/select/countdown/fight sequencer with per-player cursors, blink and fight_start pulse.
// All outputs registered, one cycle after the triggering input; inputs are never stalled.
module charselect_ctrl
   import charselect_pkg::*;
#(
   parameter int NUM_CHARS    = 4,
   parameter int COUNT_FRAMES = 180,
   parameter int BLINK_FRAMES = 15
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   charselect_ctrl_if.master  bus
);
   localparam int CW = $clog2(NUM_CHARS);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   phase_e        state_q, state_d;
   logic          start_hist_q, start_p;
   logic          p1_back, p2_back, any_back;
   logic          p1_locked, p2_locked;
   logic [CW-1:0] p1_cursor, p2_cursor;
   logic          enable_move, enable_lock, reload, from_title;
   logic [1:0]    scr_q, scr_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          fs_q, fs_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          blink_q, blink_d;

   assign start_p  = bus.start_btn & ~start_hist_q;
   assign any_back = p1_back | p2_back;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) state_q <= PH_TITLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         PH_TITLE:     if (start_p) state_d = PH_SELECT;
         PH_SELECT:    if (p1_locked && p2_locked && !any_back) state_d = PH_COUNTDOWN;
         PH_COUNTDOWN: begin
            if (any_back)
               state_d = PH_SELECT;
            else if (bus.frame_tick && cnt_q == 8'd1)
               state_d = PH_FIGHT;
         end
         PH_FIGHT:     if (bus.fight_over) state_d = PH_SELECT;
         default:      state_d = PH_TITLE;
      endcase
   end

   always_comb begin
      scr_d       = phase_screen(state_d);
      fs_d        = (state_q == PH_COUNTDOWN) && (state_d == PH_FIGHT);
      enable_move = (state_q == PH_SELECT);
      enable_lock = (state_q == PH_SELECT) || (state_q == PH_COUNTDOWN);
      from_title  = (state_q == PH_TITLE);
      // Title entry restores default cursors; fight exit keeps them but drops both locks.
      reload      = (state_d == PH_SELECT) && (from_title || state_q == PH_FIGHT);
      cnt_d       = '0;
      if (state_q == PH_SELECT && state_d == PH_COUNTDOWN)
         cnt_d = 8'(COUNT_FRAMES);
      else if (state_q == PH_COUNTDOWN && state_d == PH_COUNTDOWN)
         cnt_d = bus.frame_tick ? cnt_q - 8'd1 : cnt_q;
      bcnt_d  = '0;
      blink_d = 1'b0;
      if (state_d == PH_SELECT || state_d == PH_COUNTDOWN) begin
         bcnt_d  = bcnt_q;
         blink_d = blink_q;
         if (bus.frame_tick) begin
            if (bcnt_q == BLINK_LAST) begin
               bcnt_d  = '0;
               blink_d = ~blink_q;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         start_hist_q <= 1'b0;
         scr_q        <= SCR_TITLE;
         cnt_q        <= '0;
         fs_q         <= 1'b0;
         bcnt_q       <= '0;
         blink_q      <= 1'b0;
      end else begin
         start_hist_q <= bus.start_btn;
         scr_q        <= scr_d;
         cnt_q        <= cnt_d;
         fs_q         <= fs_d;
         bcnt_q       <= bcnt_d;
         blink_q      <= blink_d;
      end
   end

   charselect_player #(.NUM_CHARS(NUM_CHARS), .INIT(0)) u_p1 (
      .vga_clk      (vga_clk),
      .reset_n      (reset_n),
      .key_left     (bus.p1_left),
      .key_right    (bus.p1_right),
      .key_ok       (bus.p1_ok),
      .key_back     (bus.p1_back),
      .enable_move  (enable_move),
      .enable_lock  (enable_lock),
      .reload       (reload),
      .reload_value (from_title ? '0 : p1_cursor),
      .cursor       (p1_cursor),
      .locked       (p1_locked),
      .back_pressed (p1_back)
   );

   charselect_player #(.NUM_CHARS(NUM_CHARS), .INIT(NUM_CHARS - 1)) u_p2 (
      .vga_clk      (vga_clk),
      .reset_n      (reset_n),
      .key_left     (bus.p2_left),
      .key_right    (bus.p2_right),
      .key_ok       (bus.p2_ok),
      .key_back     (bus.p2_back),
      .enable_move  (enable_move),
      .enable_lock  (enable_lock),
      .reload       (reload),
      .reload_value (from_title ? CW'(NUM_CHARS - 1) : p2_cursor),
      .cursor       (p2_cursor),
      .locked       (p2_locked),
      .back_pressed (p2_back)
   );

   assign bus.screen_sel   = scr_q;
   assign bus.p1_cursor    = p1_cursor;
   assign bus.p2_cursor    = p2_cursor;
   assign bus.p1_locked    = p1_locked;
   assign bus.p2_locked    = p2_locked;
   assign bus.cursor_blink = blink_q;
   assign bus.countdown    = cnt_q;
   assign bus.fight_start  = fs_q;
endmodule

// File: tb/tb_charselect_ctrl.sv
// Directed bench for charselect_ctrl with NUM_CHARS=4, COUNT_FRAMES=3, BLINK_FRAMES=2.
module tb_charselect_ctrl;
   localparam logic [3:0] K0 = 4'b0000;
   localparam logic [3:0] KL = 4'b1000;
   localparam logic [3:0] KR = 4'b0100;
   localparam logic [3:0] KO = 4'b0010;
   localparam logic [3:0] KB = 4'b0001;

   typedef struct {
      logic       start;
      logic [3:0] k1;     // left,right,ok,back
      logic [3:0] k2;
      logic       ft;
      logic       fo;
      logic [1:0] scr;
      logic [1:0] c1;
      logic [1:0] c2;
      logic       l1;
      logic       l2;
      logic       bl;
      logic [7:0] cnt;
      logic       fs;
   } vec_t;

   logic vga_clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];

   charselect_ctrl_if #(.NUM_CHARS(4)) bus ();

   charselect_ctrl #(.NUM_CHARS(4), .COUNT_FRAMES(3), .BLINK_FRAMES(2)) dut (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 vga_clk = ~vga_clk;

   function automatic logic [17:0] pack_exp(input vec_t v);
      return {v.scr, v.c1, v.c2, v.l1, v.l2, v.bl, v.cnt, v.fs};
   endfunction

   function automatic logic [17:0] pack_act();
      return {bus.screen_sel, bus.p1_cursor, bus.p2_cursor, bus.p1_locked,
              bus.p2_locked, bus.cursor_blink, bus.countdown, bus.fight_start};
   endfunction

   // packed layout: scr[17:16] c1[15:14] c2[13:12] l1 l2 blink cnt[8:1] fs
   task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (scr,c1,c2,l1,l2,blink,cnt,fs)", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.start_btn = v.start;
      {bus.p1_left, bus.p1_right, bus.p1_ok, bus.p1_back} = v.k1;
      {bus.p2_left, bus.p2_right, bus.p2_ok, bus.p2_back} = v.k2;
      bus.frame_tick = v.ft;
      bus.fight_over = v.fo;
   endtask

   task automatic idle_inputs();
      drive(vec_t'{1'b0, K0, K0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});
   endtask

   task automatic cycle();
      @(posedge vga_clk);
      #1;
   endtask

   localparam logic [17:0] RST_EXP = {2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};

   initial begin
      logic [17:0] a;
      idle_inputs();

      //          start k1     k2    ft fo | scr c1 c2 l1 l2 bl cnt fs
      tbl.push_back(vec_t'{1, K0,    K0,    0, 0, 1, 0, 3, 0, 0, 0, 8'd0, 0}); // 0 start
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 0, 3, 0, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, KL,    K0,    0, 0, 1, 3, 3, 0, 0, 0, 8'd0, 0}); // 2 p1 wrap down
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 3, 3, 0, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, K0,    KR,    0, 0, 1, 3, 0, 0, 0, 0, 8'd0, 0}); // 4 p2 wrap up
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 3, 0, 0, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, K0,    KR,    0, 0, 1, 3, 1, 0, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 3, 1, 0, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, K0,    KR,    0, 0, 1, 3, 2, 0, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 3, 2, 0, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, K0,    KR,    0, 0, 1, 3, 3, 0, 0, 0, 8'd0, 0}); // 10
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 3, 3, 0, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, KL|KR, K0,    0, 0, 1, 3, 3, 0, 0, 0, 8'd0, 0}); // 12 L+R no move
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 3, 3, 0, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, KR,    K0,    0, 0, 1, 0, 3, 0, 0, 0, 8'd0, 0}); // 14
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 0, 3, 0, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, KO,    K0,    0, 0, 1, 0, 3, 1, 0, 0, 8'd0, 0}); // 16 p1 lock
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 0, 3, 1, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, KL,    K0,    0, 0, 1, 0, 3, 1, 0, 0, 8'd0, 0}); // 18 locked: no move
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 0, 3, 1, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, K0,    KO|KB, 0, 0, 1, 0, 3, 1, 0, 0, 8'd0, 0}); // 20 ok+back: unlocked
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 0, 3, 1, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, KB,    K0,    0, 0, 1, 0, 3, 0, 0, 0, 8'd0, 0}); // 22 p1 unlock
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 0, 3, 0, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{1, K0,    K0,    0, 0, 1, 0, 3, 0, 0, 0, 8'd0, 0}); // 24 start ignored
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 0, 3, 0, 0, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, KO,    KO,    0, 0, 1, 0, 3, 1, 1, 0, 8'd0, 0}); // 26 both lock
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 0, 3, 1, 1, 0, 8'd3, 0}); // 27 countdown
      tbl.push_back(vec_t'{0, K0,    K0,    1, 0, 1, 0, 3, 1, 1, 0, 8'd2, 0});
      tbl.push_back(vec_t'{0, K0,    KB,    1, 0, 1, 0, 3, 1, 0, 1, 8'd0, 0}); // 29 back beats tick
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 0, 3, 1, 0, 1, 8'd0, 0});
      tbl.push_back(vec_t'{0, K0,    KO,    0, 0, 1, 0, 3, 1, 1, 1, 8'd0, 0});
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 0, 3, 1, 1, 1, 8'd3, 0}); // 32
      tbl.push_back(vec_t'{0, KL,    KO,    0, 0, 1, 0, 3, 1, 1, 1, 8'd3, 0}); // 33 ignored keys
      tbl.push_back(vec_t'{0, K0,    K0,    1, 0, 1, 0, 3, 1, 1, 1, 8'd2, 0});
      tbl.push_back(vec_t'{0, K0,    K0,    1, 0, 1, 0, 3, 1, 1, 0, 8'd1, 0});
      tbl.push_back(vec_t'{0, K0,    K0,    1, 0, 2, 0, 3, 1, 1, 0, 8'd0, 1}); // 36 fight_start
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 2, 0, 3, 1, 1, 0, 8'd0, 0}); // 37 pulse ends
      tbl.push_back(vec_t'{1, KB,    K0,    0, 0, 2, 0, 3, 1, 1, 0, 8'd0, 0}); // 38 ignored in fight
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 2, 0, 3, 1, 1, 0, 8'd0, 0});
      tbl.push_back(vec_t'{0, K0,    K0,    0, 1, 1, 0, 3, 0, 0, 0, 8'd0, 0}); // 40 fight_over
      tbl.push_back(vec_t'{0, K0,    K0,    0, 0, 1, 0, 3, 0, 0, 0, 8'd0, 0});

      repeat (2) @(negedge vga_clk);
      check("reset_state", pack_act(), RST_EXP);
      reset_n = 1'b1;
      @(negedge vga_clk);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         cycle();
         check($sformatf("vec%0d", i), pack_act(), pack_exp(tbl[i]));
         @(negedge vga_clk);
      end
      idle_inputs();

      // held key: one decrement only (0 -> 3)
      bus.p1_left = 1'b1;
      repeat (100) cycle();
      check("held_left", {6'd0, bus.p1_cursor}, {6'd0, 2'd3});
      @(negedge vga_clk);
      bus.p1_left = 1'b0;
      cycle();

      // blink toggles after BLINK_FRAMES ticks
      @(negedge vga_clk);
      bus.frame_tick = 1'b1;
      cycle();
      check("blink_tick1", {17'd0, bus.cursor_blink}, 18'd0);
      @(negedge vga_clk);
      bus.frame_tick = 1'b0;
      cycle();
      @(negedge vga_clk);
      bus.frame_tick = 1'b1;
      cycle();
      check("blink_tick2", {17'd0, bus.cursor_blink}, 18'd1);
      @(negedge vga_clk);
      bus.frame_tick = 1'b0;

      // reset in the middle of a countdown
      bus.p1_ok = 1'b1;
      bus.p2_ok = 1'b1;
      cycle();
      @(negedge vga_clk);
      bus.p1_ok = 1'b0;
      bus.p2_ok = 1'b0;
      cycle();
      check("cd_entry", {10'd0, bus.countdown}, 18'd3);
      @(negedge vga_clk);
      bus.frame_tick = 1'b1;
      cycle();
      check("cd_tick", {10'd0, bus.countdown}, 18'd2);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset", pack_act(), RST_EXP);
      @(negedge vga_clk);
      bus.frame_tick = 1'b0;
      cycle();
      @(negedge vga_clk);
      reset_n = 1'b1;
      a = '0;
      for (int i = 0; i < 4; i++) begin
         bus.frame_tick = i[0];
         cycle();
         a = a | {17'd0, bus.fight_start};
         @(negedge vga_clk);
      end
      bus.frame_tick = 1'b0;
      check("post_reset_title", pack_act(), RST_EXP);
      check("no_fight_start", a, 18'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
